// File: rtl/spi_master.sv
// SPI mode-0 master for SD-card style links: byte transfers, an 80-clock INIT
// preamble with CS and MOSI held high, and explicit chip-select commands.
module spi_master #(
  parameter int DIV_FAST = 1,
  parameter int DIV_SLOW = 125
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] cmd,
  input  logic [7:0] din,
  input  logic       slow,
  output logic       busy,
  output logic       done,
  output logic [7:0] dout,
  output logic       spi_cs,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  localparam int DIV_MAX = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
  localparam int CW      = $clog2(DIV_MAX + 1);

  localparam logic [CW-1:0] FAST_M1 = CW'(DIV_FAST - 1);
  localparam logic [CW-1:0] SLOW_M1 = CW'(DIV_SLOW - 1);

  localparam logic [7:0] XFER_LAST = 8'd15;
  localparam logic [7:0] INIT_LAST = 8'd159;

  typedef enum logic [1:0] {
    CMD_XFER    = 2'b00,
    CMD_INIT    = 2'b01,
    CMD_CS_LOW  = 2'b10,
    CMD_CS_HIGH = 2'b11
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    INIT
  } state_t;

  state_t        state;
  logic [CW-1:0] h_m1;
  logic [CW-1:0] div_cnt;
  logic [7:0]    tog_cnt;
  logic [7:0]    tx_sr;
  logic [7:0]    rx_sr;
  logic [7:0]    last_tog;

  assign last_tog = (state == INIT) ? INIT_LAST : XFER_LAST;

  // NOTE: every register here is a handful of flops, so all of them take the
  // async reset; a true memory array would not, since reset can't reach RAM.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      dout     <= 8'hFF;
      spi_cs   <= 1'b1;
      spi_sclk <= 1'b0;
      spi_mosi <= 1'b1;
      h_m1     <= '0;
      div_cnt  <= '0;
      tog_cnt  <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every right-hand side
      // reads the pre-edge value regardless of statement order.
      done <= 1'b0;
      case (state)
        IDLE: begin
          spi_mosi <= 1'b1;
          if (start) begin
            case (cmd_t'(cmd))
              CMD_XFER: begin
                state    <= XFER;
                busy     <= 1'b1;
                tx_sr    <= din;
                spi_mosi <= din[7];
                h_m1     <= slow ? SLOW_M1 : FAST_M1;
                div_cnt  <= slow ? SLOW_M1 : FAST_M1;
                tog_cnt  <= '0;
              end
              CMD_INIT: begin
                state    <= INIT;
                busy     <= 1'b1;
                spi_cs   <= 1'b1;
                h_m1     <= slow ? SLOW_M1 : FAST_M1;
                div_cnt  <= slow ? SLOW_M1 : FAST_M1;
                tog_cnt  <= '0;
              end
              CMD_CS_LOW: begin
                spi_cs <= 1'b0;
                done   <= 1'b1;
              end
              default: begin
                spi_cs <= 1'b1;
                done   <= 1'b1;
              end
            endcase
          end
        end

        XFER, INIT: begin
          // div_cnt counts H-1 down to 0, so H=1 toggles on every cycle
          if (div_cnt != '0) begin
            div_cnt <= div_cnt - 1'b1;
          end else begin
            div_cnt  <= h_m1;
            spi_sclk <= ~spi_sclk;
            tog_cnt  <= tog_cnt + 8'd1;
            if (tog_cnt == last_tog) begin
              state    <= IDLE;
              busy     <= 1'b0;
              done     <= 1'b1;
              spi_mosi <= 1'b1;
              if (state == XFER) dout <= rx_sr;
            end else if (state == XFER) begin
              if (!spi_sclk) begin
                rx_sr <= {rx_sr[6:0], spi_miso};
              end else begin
                tx_sr    <= {tx_sr[6:0], 1'b0};
                spi_mosi <= tx_sr[6];
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter DIV_FAST, default 1, giving the SCLK half-period in clock cycles for fast mode (must be at least 1).
REQ-002 SHALL have parameter DIV_SLOW, default 125, giving the SCLK half-period in clock cycles for slow mode (400 kHz at 100 MHz; must be at least 1).
REQ-003 SHALL have port clock, input, 1 bit: the single system clock; all logic is rising-edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: command request, sampled only while idle.
REQ-006 SHALL have port cmd, input, 2 bits: 00 XFER byte, 01 INIT, 10 CS_LOW, 11 CS_HIGH.
REQ-007 SHALL have port din, input, 8 bits: byte to transmit, MSB first.
REQ-008 SHALL have port slow, input, 1 bit: selects DIV_SLOW (1) or DIV_FAST (0), latched at acceptance.
REQ-009 SHALL have port busy, output, 1 bit: an XFER or INIT is in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port dout, output, 8 bits: last byte received.
REQ-012 SHALL have port spi_cs, output, 1 bit: card chip select, active low.
REQ-013 SHALL have port spi_sclk, output, 1 bit: SPI clock, mode 0, idle low.
REQ-014 SHALL have port spi_mosi, output, 1 bit: serial data to the card.
REQ-015 SHALL have port spi_miso, input, 1 bit: serial data from the card.

Function
REQ-016 SHALL implement states IDLE, XFER and INIT, and SHALL accept a command only in IDLE with start=1.
REQ-017 SHALL ignore start while busy=1, with no queuing and no effect on the transfer in progress.
REQ-018 SHALL, for XFER, set busy=1 and drive spi_mosi=din[7] on the cycle after acceptance, and SHALL latch H (DIV_SLOW or DIV_FAST per slow) and din at acceptance.
REQ-019 SHALL toggle spi_sclk every H cycles after busy rises, for exactly 16 toggles in XFER, starting and ending low.
REQ-020 SHALL sample spi_miso into the receive shift register at each clock edge that drives spi_sclk from 0 to 1.
REQ-021 SHALL shift the next din bit onto spi_mosi on each spi_sclk falling edge except the last.
REQ-022 SHALL, at the 16th toggle, update dout with the received byte (first-sampled bit is dout[7]), deassert busy, and pulse done for one cycle; done therefore appears 16*H cycles after busy rises.
REQ-023 SHALL, for INIT, hold spi_cs=1 and spi_mosi=1, produce 160 toggles (80 clocks) at period H, leave dout unchanged, then deassert busy and pulse done 160*H cycles after busy rises.
REQ-024 SHALL, for CS_LOW and CS_HIGH, set spi_cs to 0 or 1 respectively and pulse done on the cycle after acceptance, with busy remaining 0.
REQ-025 SHALL leave spi_cs unaffected by XFER.
REQ-026 SHALL drive spi_mosi=1 whenever idle.
REQ-027 SHALL keep done=0 at all times other than the completion cycles defined above.
REQ-028 SHALL implement the half-period counter and bit counter such that no off-by-one occurs at H=1, i.e. spi_sclk toggles every cycle.

Reset
REQ-029 SHALL, while reset=1, immediately force spi_cs=1, spi_sclk=0, spi_mosi=1, busy=0, done=0, dout=8'hFF and state IDLE, independent of clock.
REQ-030 SHALL treat reset asserted mid-XFER or mid-INIT as an abort, with no done pulse and no dout update, and SHALL accept the first command after reset release normally.

Verification
REQ-031 SHALL be verified by this scenario: assert reset with no clock edge -> spi_cs=1, spi_sclk=0, spi_mosi=1, busy=0, done=0, dout=8'hFF.
REQ-032 SHALL be verified by this scenario: XFER din=8'hA5, slow=0, DIV_FAST=1, slave returns 8'h3C -> spi_mosi at the 8 rising edges is 1,0,1,0,0,1,0,1; dout=8'h3C; done 16 cycles after busy rises; 8 spi_sclk pulses.
REQ-033 SHALL be verified by this scenario: INIT with slow=1, DIV_SLOW=3 -> exactly 80 spi_sclk pulses, each high for 3 cycles; spi_cs=1 and spi_mosi=1 throughout; done 480 cycles after busy rises.
REQ-034 SHALL be verified by this scenario: CS_LOW, XFER 8'hFF, CS_HIGH -> spi_cs=0 from the cycle after the first acceptance, through the whole XFER, and back to 1 after CS_HIGH; three done pulses.
REQ-035 SHALL be verified by this scenario: start with cmd=CS_HIGH pulsed during an XFER -> ignored; spi_cs unchanged; exactly one done pulse.
REQ-036 SHALL be verified by this scenario: reset asserted after the 5th rising edge of an XFER -> outputs take reset values immediately with no done pulse; a following XFER 8'h00 completes with done after 16*H cycles.
